// File: rtl/regd.sv
// rtl/regd.sv - 1-to-4 demultiplexing register bank with valid/ready intake
// Words steer to qa..qd by {c1,c2} or a round-robin pointer; per-channel valid/ack.
module regd #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    output logic             ready,
    input  logic             c1,
    input  logic             c2,
    input  logic             auto,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] qc,
    output logic [WIDTH-1:0] qd,
    output logic             va,
    output logic             vb,
    output logic             vc,
    output logic             vd,
    input  logic             acka,
    input  logic             ackb,
    input  logic             ackc,
    input  logic             ackd,
    output logic [1:0]       ptr,
    output logic [CNTW-1:0]  stall_cnt
);

    logic [3:0][WIDTH-1:0] q_q, q_d;
    logic [3:0]            v_q, v_d;
    logic [3:0]            ack;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            dest;
    logic [CNTW-1:0]       stall_q, stall_d;
    logic                  accept;

    assign ack = {ackd, ackc, ackb, acka};

    always_comb begin
        dest    = auto ? ptr_q : {c1, c2};
        // An ack on the destination frees the slot this cycle, giving one word per cycle.
        ready   = ~v_q[dest] | ack[dest];
        accept  = valid & ready;
        q_d     = q_q;
        v_d     = v_q & ~ack;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        if (accept) begin
            q_d[dest] = d;
            v_d[dest] = 1'b1;
            if (auto) begin
                ptr_d = ptr_q + 2'd1;
            end
        end
        if (valid && !ready && (stall_q != {CNTW{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            v_q     <= '0;
            ptr_q   <= '0;
            stall_q <= '0;
        end else begin
            q_q     <= q_d;
            v_q     <= v_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
        end
    end

    assign qa        = q_q[0];
    assign qb        = q_q[1];
    assign qc        = q_q[2];
    assign qd        = q_q[3];
    assign va        = v_q[0];
    assign vb        = v_q[1];
    assign vc        = v_q[2];
    assign vd        = v_q[3];
    assign ptr       = ptr_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_regd.sv
// tb/tb_regd.sv - scoreboard bench for regd, plus a CNTW=2 instance for saturation
module tb_regd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d;
    logic       valid, c1, c2, auto;
    logic       acka, ackb, ackc, ackd;
    logic       ready, ready_s;
    logic [3:0] qa, qb, qc, qd, qa_s, qb_s, qc_s, qd_s;
    logic       va, vb, vc, vd, va_s, vb_s, vc_s, vd_s;
    logic [1:0] ptr, ptr_s;
    logic [7:0] stall_cnt;
    logic [1:0] stall_s;

    always #5 clk = ~clk;

    regd #(.WIDTH(4), .CNTW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .d(d), .valid(valid), .ready(ready),
        .c1(c1), .c2(c2), .auto(auto),
        .qa(qa), .qb(qb), .qc(qc), .qd(qd),
        .va(va), .vb(vb), .vc(vc), .vd(vd),
        .acka(acka), .ackb(ackb), .ackc(ackc), .ackd(ackd),
        .ptr(ptr), .stall_cnt(stall_cnt)
    );

    regd #(.WIDTH(4), .CNTW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .d(d), .valid(valid), .ready(ready_s),
        .c1(c1), .c2(c2), .auto(auto),
        .qa(qa_s), .qb(qb_s), .qc(qc_s), .qd(qd_s),
        .va(va_s), .vb(vb_s), .vc(vc_s), .vd(vd_s),
        .acka(acka), .ackb(ackb), .ackc(ackc), .ackd(ackd),
        .ptr(ptr_s), .stall_cnt(stall_s)
    );

    logic [3:0][3:0] q_all;
    logic [3:0]      v_all;
    assign q_all = {qd, qc, qb, qa};
    assign v_all = {vd, vc, vb, va};

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] m_q [4];
    logic [3:0] m_v;
    logic [1:0] m_ptr;
    int         m_stall;
    int         m_stall_s;
    logic [5:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_q[i] = '0;
        m_v       = '0;
        m_ptr     = '0;
        m_stall   = 0;
        m_stall_s = 0;
        sb_q.delete();
    endtask

    task automatic check_bank();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("q%0d", i), 32'(q_all[i]), 32'(m_q[i]));
        end
        check("v", 32'(v_all), 32'(m_v));
        check("ptr", 32'(ptr), 32'(m_ptr));
        check("stall", 32'(stall_cnt), 32'(m_stall));
        check("stall_sat", 32'(stall_s), 32'(m_stall_s));
    endtask

    // Drive one cycle starting at a negedge; returns at the following negedge.
    task automatic cycle(input logic vl, input logic [3:0] dv, input logic [1:0] sel,
                         input logic au, input logic [3:0] ak);
        logic [1:0] dest;
        logic       m_ready;
        logic [5:0] ent;
        valid = vl; d = dv; {c1, c2} = sel; auto = au;
        {ackd, ackc, ackb, acka} = ak;
        #1;
        dest    = au ? m_ptr : sel;
        m_ready = ~m_v[dest] | ak[dest];
        check("ready", 32'(ready), 32'(m_ready));
        m_v = m_v & ~ak;
        if (vl && m_ready) begin
            sb_q.push_back({dest, dv});
            m_q[dest] = dv;
            m_v[dest] = 1'b1;
            if (au) m_ptr = m_ptr + 2'd1;
        end
        if (vl && !m_ready) begin
            if (m_stall < 255) m_stall++;
            if (m_stall_s < 3) m_stall_s++;
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            check("sb_q", 32'(q_all[ent[5:4]]), 32'(ent[3:0]));
            check("sb_v", 32'(v_all[ent[5:4]]), 32'd1);
        end
        check_bank();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; d = '0; c1 = 1'b0; c2 = 1'b0; auto = 1'b0;
        acka = 1'b0; ackb = 1'b0; ackc = 1'b0; ackd = 1'b0;
        model_reset();
        #2;
        check_bank();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(ready), 32'd1);

        // Manual steering into channel c
        cycle(1'b1, 4'hA, 2'b10, 1'b0, 4'b0000);
        cycle(1'b0, 4'h0, 2'b10, 1'b0, 4'b0000);

        // Asynchronous reset mid-run with va=vb=1 and ptr=2
        cycle(1'b1, 4'h1, 2'b00, 1'b1, 4'b0000);
        cycle(1'b1, 4'h2, 2'b00, 1'b1, 4'b0000);
        check("pre_reset_ptr", 32'(ptr), 32'd2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_bank();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset2", 32'(ready), 32'd1);

        // Round-robin fill and wrap, then backpressure
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 2'b00, 1'b1, 4'b0000);
        check("rr_ptr_wrap", 32'(ptr), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'h5, 2'b00, 1'b1, 4'b0000);
        check("stall_three", 32'(stall_cnt), 32'd3);
        check("qa_held", 32'(qa), 32'd1);
        cycle(1'b1, 4'h5, 2'b00, 1'b1, 4'b0001);
        check("qa_bypass", 32'(qa), 32'd5);
        check("ptr_after_bypass", 32'(ptr), 32'd1);

        // Simultaneous ack and write on channel b
        cycle(1'b1, 4'h7, 2'b01, 1'b0, 4'b0010);
        check("qb_write_wins", 32'(qb), 32'd7);
        check("vb_stays", 32'(vb), 32'd1);
        check("stall_unchanged", 32'(stall_cnt), 32'd3);

        // Ack clears; all four at once; ack with v=0 ignored
        cycle(1'b0, 4'h0, 2'b00, 1'b0, 4'b1000);
        cycle(1'b0, 4'h0, 2'b00, 1'b0, 4'b1111);
        cycle(1'b0, 4'h0, 2'b00, 1'b0, 4'b1111);
        check("qc_retained", 32'(qc), 32'd3);

        // Saturation: fresh reset, fill a, block for six cycles
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b1, 4'h9, 2'b00, 1'b0, 4'b0000);
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'hE, 2'b00, 1'b0, 4'b0000);
        check("sat_cap", 32'(stall_s), 32'd3);
        check("stall_six", 32'(stall_cnt), 32'd6);
        check("qa_not_overwritten", 32'(qa), 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
